// File: rtl/shift_pkg.sv
// Shared encodings for the parametrised shift/rotate unit.
package shift_pkg;

  // Operation select, sampled with start.
  localparam logic [2:0] MODE_LOAD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_INV  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  // Controller states.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // True for modes that finish in the start cycle with no shift steps.
  function automatic logic is_single_cycle(input logic [2:0] m);
    return (m == MODE_LOAD) || (m == MODE_INV) || (m == MODE_RSVD);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One single-bit shift/rotate step plus the bit that step would shift out.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] value_next,
  output logic             ser_out
);

  // Next value after one step; non-shift modes pass the value through.
  always_comb begin
    value_next = value;
    case (mode)
      MODE_SHR: value_next = {ser_in, value[WIDTH-1:1]};
      MODE_SHL: value_next = {value[WIDTH-2:0], ser_in};
      MODE_ROR: value_next = {value[0], value[WIDTH-1:1]};
      MODE_ROL: value_next = {value[WIDTH-2:0], value[WIDTH-1]};
      MODE_ASR: value_next = {value[WIDTH-1], value[WIDTH-1:1]};
      default:  value_next = value;
    endcase
  end

  // Left-moving modes expose the MSB, everything else the LSB.
  always_comb begin
    ser_out = value[0];
    if (mode == MODE_SHL || mode == MODE_ROL) begin
      ser_out = value[WIDTH-1];
    end
  end

endmodule

// File: rtl/param_shift_unit.sv
// Multi-mode shift/rotate register with a start/busy/done handshake for
// multi-cycle shift-by-N operations.
module param_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   d_in,
  input  logic               ser_in,
  output logic [WIDTH-1:0]   q_out,
  output logic               ser_out,
  output logic               busy,
  output logic               done
);

  localparam logic [SHAMT_W-1:0] CntZero = '0;
  localparam logic [SHAMT_W-1:0] CntOne  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  logic               state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   step_value;

  // Shared step logic: drives both the shift datapath and ser_out.
  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .value      (data_q),
    .mode       (mode_q),
    .ser_in     (ser_in),
    .value_next (step_value),
    .ser_out    (ser_out)
  );

  // Next-state: operation launch in IDLE, one step per cycle in SHIFT.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          case (mode)
            MODE_INV:  data_d = ~d_in;
            MODE_RSVD: data_d = data_q;
            default:   data_d = d_in;
          endcase
          if (is_single_cycle(mode) || shamt == CntZero) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = shamt;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_value;
        cnt_d  = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LOAD;
      cnt_q   <= CntZero;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q_out = data_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_param_shift_unit.sv
// Directed bench for param_shift_unit at WIDTH=8, SHAMT_W=4.
module tb_param_shift_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] mode;
  logic [3:0] shamt;
  logic [7:0] d_in;
  logic       ser_in;
  logic [7:0] q_out;
  logic       ser_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_shift_unit #(
    .WIDTH   (8),
    .SHAMT_W (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mode    (mode),
    .shamt   (shamt),
    .d_in    (d_in),
    .ser_in  (ser_in),
    .q_out   (q_out),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an operation and wait (bounded) for done; reports final q and busy cycles.
  task automatic run_op(input logic [2:0] m, input logic [7:0] d, input logic [3:0] n,
                        input logic s, output logic [7:0] fq, output int bc);
    int guard;
    start = 1'b1; mode = m; d_in = d; shamt = n; ser_in = s;
    tick();
    start = 1'b0;
    bc    = 0;
    guard = 0;
    while (!done && guard < 40) begin
      if (busy) bc++;
      tick();
      guard++;
    end
    check("op_done_seen", {31'd0, done}, 32'd1);
    fq = q_out;
  endtask

  logic [7:0] fq;
  int         bc;
  int         done_cnt;

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 3'b000; shamt = 4'd0; d_in = 8'h00; ser_in = 1'b0;
    tick();
    tick();
    check("rst_q", q_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ser_out", ser_out, 1'b0);
    reset_n = 1'b1;
    tick();
    check("idle_q", q_out, 8'h00);

    // Load
    start = 1'b1; mode = 3'b000; d_in = 8'hA5;
    tick();
    start = 1'b0;
    check("load_q", q_out, 8'hA5);
    check("load_done", done, 1'b1);
    check("load_busy", busy, 1'b0);
    tick();
    check("load_done_clr", done, 1'b0);

    // Logical shift right by 3 with ser_in=1
    start = 1'b1; mode = 3'b001; d_in = 8'hB4; shamt = 4'd3; ser_in = 1'b1;
    tick();
    start = 1'b0;
    check("shr_q0", q_out, 8'hB4);
    check("shr_busy0", busy, 1'b1);
    check("shr_done0", done, 1'b0);
    check("shr_so0", ser_out, 1'b0);
    tick();
    check("shr_q1", q_out, 8'hDA);
    check("shr_busy1", busy, 1'b1);
    check("shr_so1", ser_out, 1'b0);
    tick();
    check("shr_q2", q_out, 8'hED);
    check("shr_busy2", busy, 1'b1);
    check("shr_so2", ser_out, 1'b1);
    tick();
    check("shr_q3", q_out, 8'hF6);
    check("shr_busy3", busy, 1'b0);
    check("shr_done3", done, 1'b1);
    tick();
    check("shr_done_clr", done, 1'b0);

    // Shift mode with shamt=0 completes immediately
    run_op(3'b001, 8'h5A, 4'd0, 1'b1, fq, bc);
    check("shr0_q", fq, 8'h5A);
    check("shr0_busy_cycles", bc, 0);

    // Rotate left by 9 wraps to one step
    run_op(3'b101, 8'h81, 4'd9, 1'b0, fq, bc);
    check("rol9_q", fq, 8'h03);
    check("rol9_busy_cycles", bc, 9);
    tick();
    check("rol9_done_clr", done, 1'b0);

    // ASR by 15 saturates
    run_op(3'b110, 8'h90, 4'd15, 1'b0, fq, bc);
    check("asr15_q", fq, 8'hFF);
    check("asr15_busy_cycles", bc, 15);

    // Complement then reserved
    run_op(3'b011, 8'h3C, 4'd5, 1'b0, fq, bc);
    check("inv_q", fq, 8'hC3);
    check("inv_busy_cycles", bc, 0);
    run_op(3'b111, 8'h00, 4'd5, 1'b0, fq, bc);
    check("rsvd_q", fq, 8'hC3);
    check("rsvd_busy_cycles", bc, 0);
    tick();
    check("rsvd_done_clr", done, 1'b0);

    // Start during busy is ignored
    start = 1'b1; mode = 3'b010; d_in = 8'h01; shamt = 4'd4; ser_in = 1'b0;
    tick();
    start = 1'b0;
    check("shl_q0", q_out, 8'h01);
    tick();
    check("shl_q1", q_out, 8'h02);
    start = 1'b1; mode = 3'b000; d_in = 8'hFF;
    tick();
    start = 1'b0;
    check("shl_ign_q", q_out, 8'h04);
    check("shl_ign_busy", busy, 1'b1);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      if (i == 2) check("shl_final_q", q_out, 8'h10);
      tick();
    end
    check("shl_done_pulses", done_cnt, 1);
    check("shl_hold_q", q_out, 8'h10);

    // Reset mid-shift aborts with no done
    start = 1'b1; mode = 3'b001; d_in = 8'hF0; shamt = 4'd8; ser_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_busy_pre", busy, 1'b1);
    reset_n = 1'b0;
    tick();
    check("abort_q", q_out, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("abort_no_done", done_cnt, 0);

    // Fresh shift-left after reset; ser_out shows MSB in left modes
    start = 1'b1; mode = 3'b010; d_in = 8'hC0; shamt = 4'd1; ser_in = 1'b1;
    tick();
    start = 1'b0;
    check("fresh_q0", q_out, 8'hC0);
    check("fresh_so_msb", ser_out, 1'b1);
    tick();
    check("fresh_q1", q_out, 8'h81);
    check("fresh_done", done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
